// File: rtl/csa_accum_if.sv
// Operand-in / result-out handshake bundle for the carry-save accumulator.
// The slave modport is the accumulator's view of the bundle; the master modport is the producer/consumer view.
interface csa_accum_if #(
    parameter int WIDTH = 8,
    parameter int ACC_W = WIDTH + 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [7:0]       out_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count
    );
endinterface

// File: rtl/csa_accum.sv
// Streaming multi-operand accumulator: one 3:2 carry-save compression per beat,
// and a single carry-propagate add when the group closes.
module csa_accum #(
    parameter int WIDTH = 8,
    parameter int ACC_W = WIDTH + 4
) (
    input logic        clk,
    input logic        rst,
    csa_accum_if.slave bus
);

    typedef enum logic [1:0] {ACC, RESOLVE, HOLD} state_t;

    state_t           state;
    state_t           state_next;
    logic [ACC_W-1:0] s_reg;
    logic [ACC_W-1:0] c_reg;
    logic [ACC_W-1:0] data_ext;
    logic [ACC_W-1:0] maj;
    logic [7:0]       count_reg;
    logic [ACC_W-1:0] sum_reg;
    logic [7:0]       count_out_reg;
    logic             valid_reg;
    logic             ready;
    logic             beat;

    assign ready         = (state == ACC) && !rst;
    assign beat          = bus.in_valid && ready;
    assign bus.in_ready  = ready;
    assign bus.out_valid = valid_reg;
    assign bus.out_sum   = sum_reg;
    assign bus.out_count = count_out_reg;

    always_comb begin
        data_ext = '0;
        data_ext[WIDTH-1:0] = bus.in_data;
    end

    // Majority of the three inputs becomes the carry, shifted one place up.
    assign maj = (s_reg & c_reg) | (c_reg & data_ext) | (data_ext & s_reg);

    always_comb begin
        state_next = state;
        case (state)
            ACC:     if (beat && bus.in_last) state_next = RESOLVE;
            RESOLVE: state_next = HOLD;
            HOLD:    if (valid_reg && bus.out_ready) state_next = ACC;
            default: state_next = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ACC;
            s_reg         <= '0;
            c_reg         <= '0;
            count_reg     <= '0;
            sum_reg       <= '0;
            count_out_reg <= '0;
            valid_reg     <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                ACC: begin
                    if (beat) begin
                        s_reg     <= s_reg ^ c_reg ^ data_ext;
                        c_reg     <= maj << 1;
                        count_reg <= count_reg + 8'd1;
                    end
                end
                RESOLVE: begin
                    sum_reg       <= s_reg + c_reg;
                    count_out_reg <= count_reg;
                    s_reg         <= '0;
                    c_reg         <= '0;
                    count_reg     <= '0;
                    valid_reg     <= 1'b1;
                end
                HOLD: begin
                    if (bus.out_ready) valid_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_accum.sv
// Self-checking bench for csa_accum: directed cases plus randomised groups,
// scored against a plain-arithmetic sum model via an expected-result queue.
module tb_csa_accum;

    localparam int    WIDTH = 8;
    localparam int    ACC_W = 12;
    localparam longint MOD  = 64'd1 << ACC_W;

    typedef struct {
        logic [ACC_W-1:0] sum;
        logic [7:0]       count;
    } result_t;

    logic clk = 1'b0;
    logic rst;
    logic ready_manual;
    logic ready_rand;
    bit   rand_ready_en = 1'b0;

    int checks = 0;
    int errors = 0;

    result_t          exp_q[$];
    logic [WIDTH-1:0] beat_q[$];

    always #5 clk = ~clk;

    csa_accum_if #(.WIDTH(WIDTH), .ACC_W(ACC_W)) bus ();

    csa_accum #(.WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.out_ready = rand_ready_en ? ready_rand : ready_manual;

    always @(posedge clk) begin
        #1;
        ready_rand = ($urandom_range(99) < 70);
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Offers one beat and returns 1 time unit after the edge that takes it.
    task automatic sendBeat(input logic [WIDTH-1:0] data, input logic last);
        int waited = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.in_last  = last;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            waited++;
            if (waited > 2000) begin
                timeoutFail("beat_accept");
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = WIDTH'($urandom);
        bus.in_last  = 1'($urandom);
    endtask

    task automatic applyStimulus(input int gap_pct);
        result_t r;
        longint  total = 0;
        int      n = beat_q.size();
        foreach (beat_q[i]) total += longint'(beat_q[i]);
        r.sum   = ACC_W'(total % MOD);
        r.count = 8'(n % 256);
        exp_q.push_back(r);
        for (int i = 0; i < n; i++) begin
            sendBeat(beat_q[i], i == n - 1);
            if ($urandom_range(99) < gap_pct) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        beat_q.delete();
    endtask

    task automatic waitDrain();
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            timeoutFail("result_drain");
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    result_t          mon_exp;
    logic [ACC_W-1:0] prev_sum;
    logic [7:0]       prev_count;
    bit               prev_hold = 1'b0;

    // Monitor: pops one expectation per completed output handshake.
    always @(negedge clk) begin
        if (rst !== 1'b0) begin
            prev_hold = 1'b0;
        end else begin
            checkOutput("ready_valid_exclusive", longint'(bus.in_ready & bus.out_valid), 0);
            if (prev_hold) begin
                checkOutput("hold_sum_stable", bus.out_sum, prev_sum);
                checkOutput("hold_count_stable", bus.out_count, prev_count);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_result", 1, 0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    checkOutput("out_sum", bus.out_sum, mon_exp.sum);
                    checkOutput("out_count", bus.out_count, mon_exp.count);
                end
            end
            prev_hold  = bus.out_valid && !bus.out_ready;
            prev_sum   = bus.out_sum;
            prev_count = bus.out_count;
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int      waited;
        result_t r;

        rst          = 1'b1;
        ready_manual = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAA;
        bus.in_last  = 1'b1;

        repeat (3) begin
            @(negedge clk);
            checkOutput("rst_in_ready", bus.in_ready, 0);
            checkOutput("rst_out_valid", bus.out_valid, 0);
            checkOutput("rst_out_sum", bus.out_sum, 0);
            checkOutput("rst_out_count", bus.out_count, 0);
        end
        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        @(negedge clk);
        checkOutput("in_ready_after_rst", bus.in_ready, 1);
        checkOutput("out_valid_after_rst", bus.out_valid, 0);
        @(posedge clk);
        #1;

        $display("[TB] basic group");
        ready_manual = 1'b1;
        beat_q = '{8'h0B, 8'h0B, 8'h06};
        applyStimulus(0);
        @(negedge clk);
        checkOutput("latency_resolve_valid", bus.out_valid, 0);
        checkOutput("latency_resolve_ready", bus.in_ready, 0);
        @(negedge clk);
        checkOutput("latency_valid", bus.out_valid, 1);
        checkOutput("basic_sum", bus.out_sum, 12'h01C);
        checkOutput("basic_count", bus.out_count, 3);
        @(negedge clk);
        checkOutput("valid_one_cycle", bus.out_valid, 0);
        checkOutput("ready_after_handshake", bus.in_ready, 1);
        waitDrain();

        $display("[TB] wrap-around");
        repeat (20) beat_q.push_back(8'hFF);
        applyStimulus(0);
        waitDrain();
        beat_q = '{8'h7F};
        applyStimulus(0);
        waitDrain();

        $display("[TB] backpressure and gaps");
        ready_manual = 1'b0;
        beat_q = '{8'd1, 8'd2, 8'd3, 8'd4};
        applyStimulus(100);
        waited = 0;
        forever begin
            @(negedge clk);
            if (bus.out_valid) break;
            waited++;
            if (waited > 50) begin
                timeoutFail("bp_out_valid");
                break;
            end
        end
        r.sum   = 12'd9;
        r.count = 8'd1;
        exp_q.push_back(r);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd9;
        bus.in_last  = 1'b1;
        repeat (5) begin
            checkOutput("bp_in_ready", bus.in_ready, 0);
            checkOutput("bp_out_valid", bus.out_valid, 1);
            checkOutput("bp_sum", bus.out_sum, 10);
            checkOutput("bp_count", bus.out_count, 4);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        ready_manual = 1'b1;
        sendBeat(8'd9, 1'b1);
        waitDrain();

        $display("[TB] 256-beat group");
        repeat (256) beat_q.push_back(WIDTH'($urandom));
        applyStimulus(0);
        waitDrain();

        $display("[TB] reset mid-group");
        sendBeat(8'd5, 1'b0);
        sendBeat(8'd6, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_out_valid", bus.out_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        beat_q = '{8'd5};
        applyStimulus(0);
        waitDrain();

        $display("[TB] randomised groups");
        rand_ready_en = 1'b1;
        for (int g = 0; g < 1000; g++) begin
            int n;
            n = ($urandom_range(19) == 0) ? int'($urandom_range(1, 300)) : int'($urandom_range(1, 40));
            repeat (n) beat_q.push_back(WIDTH'($urandom));
            applyStimulus(15);
        end
        waitDrain();
        rand_ready_en = 1'b0;
        ready_manual  = 1'b1;
        waitDrain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
